apb4_mst: RTL and testbench

- APB4 initiator (requester) that converts a simple valid/ready request/response port into APB4 SETUP/ACCESS transfers.
- Used by bus bridges, DMA-lite engines and test harnesses to drive APB4 slave peripherals such as timers and UARTs.
- Handles one outstanding transfer at a time; the response is held in a register until the consumer accepts it.

---
 rtl/apb4_mst.sv | 218 +++++++++++++++++++++
 tb/tb_apb4_mst.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_mst.sv
// apb4_mst: APB4 requester turning a valid/ready request into one SETUP/ACCESS transfer.
// Latency: accept at cycle 0, SETUP 1, ACCESS 2 (+ wait states), response valid from cycle 3.
// Backpressure: one transfer outstanding; req_ready_o only in IDLE; response held until rsp_ready_i.
//
// Ports:
//   clk_i, rst_n_i                     clock, asynchronous active-low reset
//   req_valid_i/req_ready_o            request handshake; req_write_i, req_addr_i, req_wdata_i,
//                                      req_strb_i, req_prot_i sampled only on the accept cycle
//   rsp_valid_o/rsp_ready_i            response handshake; rsp_rdata_o (0 for writes), rsp_err_o
//   psel_o, penable_o, pwrite_o, paddr_o, pprot_o, pwdata_o, pstrb_o   APB4 requester outputs
//   pready_i, prdata_i, pslverr_i      APB4 completer inputs
//
// Optional build macro APB4_MST_TIMEOUT_EN: abort an ACCESS phase after TMO_CYCLES wait cycles
// and return rsp_err_o=1 with rsp_rdata_o=0. Without it ACCESS waits indefinitely.

module apb4_mst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TMO_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,

  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,

  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,

  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Reject configurations the datapath was not built for.
  if ((DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) || (TMO_CYCLES < 2)) begin : g_bad_cfg
    $error("apb4_mst: DATA_WIDTH must be 8/16/32 and TMO_CYCLES >= 2");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state_q,     state_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [2:0]            pprot_q,     pprot_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,     pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  // High when the ACCESS phase has used up its wait-state allowance this cycle.
  logic                  tmo_hit;

`ifdef APB4_MST_TIMEOUT_EN
  localparam int              TMO_W    = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Cleared while in SETUP so it reads zero on the first ACCESS cycle; counts wait cycles only.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_ACCESS && !pready_i) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and output-register logic. APB outputs are registered so they never glitch,
  // and the address/control/data registers are only written on accept so they hold between
  // transfers.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write_i;
          paddr_d   = req_addr_i;
          pprot_d   = req_prot_i;
          // Reads carry no write data or strobes on the bus.
          pwdata_d  = req_write_i ? req_wdata_i : '0;
          pstrb_d   = req_write_i ? req_strb_i  : '0;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        // pready_i wins over a timeout reached in the same cycle.
        if (pready_i) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
          rsp_err_d   = pslverr_i;
        end else if (tmo_hit) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pprot_o     = pprot_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_apb4_mst.sv
// tb_apb4_mst: scoreboard bench for apb4_mst with an APB4 completer memory model.
// Latency: n/a (bench).
// Backpressure: completer inserts fixed or random wait states; consumer stalls rsp_ready_i.
`timescale 1ns/1ps

module tb_apb4_mst;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_strb_i;
  logic [2:0]  req_prot_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [2:0]  pprot_o;
  logic [3:0]  pstrb_o;
  logic        pready_i, pslverr_i;
  logic [31:0] prdata_i;

  always #5 clk_i = ~clk_i;

  apb4_mst #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TMO_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pprot_o(pprot_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
  } req_t;

  req_t        apb_q[$];          // expected APB transfer attributes, in order
  logic [32:0] rsp_q[$];          // expected {err, rdata}, in order
  logic [31:0] ref_mem[int];      // reference view of the completer memory
  logic [31:0] slv_mem[int];      // completer's own storage

  int n_tests = 0;
  int n_fail  = 0;
  int fixed_waits = 0;            // <0: random 0..3 wait states per transfer
  int rsp_mode = 0;               // 0: rsp_ready tied 1, 1: random, 2: held 0
  int t_psel, t_pen, t_rsp, t_rdy;
  logic [3:0] t_strb;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Completer address map: page 0xE00 answers with PSLVERR and returns ~addr; all
  // other words are RAM whose never-written contents are addr ^ 0xA5A55A5A.
  function automatic bit is_err(input logic [31:0] a);
    return a[11:8] == 4'hE;
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : init_val(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(int'(a >> 2)) ? slv_mem[int'(a >> 2)] : init_val(a);
  endfunction

  // Reference model: what the bus must show and what the response must be.
  task automatic exp_push(input req_t r, input bit abort);
    req_t e;
    e = r;
    if (!r.w) begin e.d = '0; e.s = '0; end
    apb_q.push_back(e);
    if (abort)            rsp_q.push_back({1'b1, 32'h0});
    else if (is_err(r.a)) rsp_q.push_back({1'b1, r.w ? 32'h0 : ~r.a});
    else if (r.w) begin
      rsp_q.push_back({1'b0, 32'h0});
      ref_mem[int'(r.a >> 2)] = merge(ref_rd(r.a), r.d, r.s);
    end else              rsp_q.push_back({1'b0, ref_rd(r.a)});
  endtask

  task automatic scramble();
    req_write_i = 1'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_strb_i  = 4'($urandom);
    req_prot_i  = 3'($urandom);
  endtask

  // Called at a negedge; presents the request when req_ready_o is seen (that is cycle 0).
  task automatic issue(input req_t r, input bit abort);
    int g = 0;
    while (!req_ready_o && g < 200) begin @(negedge clk_i); g++; end
    chk("issue_req_ready", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_write_i = r.w; req_addr_i = r.a; req_wdata_i = r.d; req_strb_i = r.s; req_prot_i = r.p;
    exp_push(r, abort);
  endtask

  // Follow one transfer from cycle 1 until req_ready_o returns, counting phase cycles.
  task automatic trace(input int max);
    t_psel = 0; t_pen = 0; t_rsp = -1; t_rdy = -1; t_strb = 4'h0;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk_i);
      if (k == 1) begin req_valid_i = 1'b0; scramble(); end
      if (psel_o) t_psel++;
      if (penable_o) t_pen++;
      if (psel_o && !penable_o) t_strb = pstrb_o;
      if (rsp_valid_o && t_rsp < 0) t_rsp = k;
      if (req_ready_o) begin t_rdy = k; break; end
    end
    chk("trace_completes", t_rdy > 0, 1'b1);
  endtask

  // Completer model.
  int wcnt = 0;
  int cur_w = 0;
  initial begin
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        pready_i = 1'b0; wcnt = 0;
      end else if (psel_o && penable_o) begin
        if (wcnt >= cur_w) begin
          pready_i  = 1'b1;
          pslverr_i = is_err(paddr_o);
          if (pwrite_o)       prdata_i = $urandom;
          else if (pslverr_i) prdata_i = ~paddr_o;
          else                prdata_i = slv_rd(paddr_o);
          if (pwrite_o && !pslverr_i)
            slv_mem[int'(paddr_o >> 2)] = merge(slv_rd(paddr_o), pwdata_o, pstrb_o);
        end else begin
          pready_i = 1'b0; pslverr_i = 1'($urandom); prdata_i = $urandom;
          wcnt++;
        end
      end else begin
        pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
        wcnt = 0;
        cur_w = (fixed_waits >= 0) ? fixed_waits : int'($urandom_range(0, 3));
      end
    end
  end

  // Response consumer.
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (rsp_mode)
        0:       rsp_ready_i = 1'b1;
        1:       rsp_ready_i = 1'($urandom);
        default: rsp_ready_i = 1'b0;
      endcase
    end
  end

  // Response monitor: pops the scoreboard on each handshake.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_q.size(), 1);
        else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e[31:0]);
          chk("rsp_err", rsp_err_o, e[32]);
        end
      end
    end
  end

  // APB bus monitor: attributes at SETUP, phase ordering, stability and read zeroing.
  initial begin
    logic        p_ok, p_psel, p_pen;
    logic [71:0] p_bus;
    req_t        e;
    p_ok = 1'b0; p_psel = 1'b0; p_pen = 1'b0; p_bus = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) p_ok = 1'b0;
      else begin
        chk("penable_implies_psel", !penable_o || psel_o, 1'b1);
        if (psel_o && !penable_o) begin
          if (apb_q.size() == 0) chk("apb_unexpected_setup", apb_q.size(), 1);
          else begin
            e = apb_q.pop_front();
            chk("apb_setup_attrs", {pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o},
                {e.w, e.a, e.d, e.s, e.p});
          end
        end
        if (p_ok && p_psel && !p_pen) chk("setup_then_access", psel_o && penable_o, 1'b1);
        if (p_ok && (!psel_o || p_psel))
          chk("apb_attrs_stable", {paddr_o, pwrite_o, pprot_o, pwdata_o, pstrb_o}, p_bus);
        if (psel_o && !pwrite_o) chk("read_strb_wdata_zero", {pstrb_o, pwdata_o}, 36'h0);
        p_ok = 1'b1; p_psel = psel_o; p_pen = penable_o;
        p_bus = {paddr_o, pwrite_o, pprot_o, pwdata_o, pstrb_o};
      end
    end
  end

  initial begin
    req_t r;
    logic [31:0] a;
    int g;
    rst_n_i = 1'b0; req_valid_i = 1'b0; scramble();
    #1;
    chk("rst_apb_ctrl", {psel_o, penable_o, pwrite_o}, 3'b000);
    chk("rst_apb_data", {paddr_o, pprot_o, pwdata_o, pstrb_o}, 71'h0);
    chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 34'h0);
    chk("rst_req_ready", req_ready_o, 1'b1);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Back-to-back-capable write, zero wait states, consumer always ready.
    fixed_waits = 0; rsp_mode = 0;
    issue('{w:1'b1, a:32'h8, d:32'hDEAD_BEEF, s:4'hF, p:3'd0}, 1'b0);
    trace(40);
    chk("wr_psel_cycles", t_psel, 2);
    chk("wr_penable_cycles", t_pen, 1);
    chk("wr_pstrb", t_strb, 4'hF);
    chk("wr_rsp_cycle", t_rsp, 3);
    chk("wr_ready_cycle", t_rdy, 4);

    // Read with three wait states.
    issue('{w:1'b1, a:32'hC, d:32'h1234_5678, s:4'hF, p:3'd2}, 1'b0);
    trace(40);
    fixed_waits = 3;
    issue('{w:1'b0, a:32'hC, d:32'h0, s:4'h0, p:3'd1}, 1'b0);
    trace(40);
    chk("rd_penable_cycles", t_pen, 4);
    chk("rd_psel_cycles", t_psel, 5);
    chk("rd_pstrb", t_strb, 4'h0);
    chk("rd_rsp_cycle", t_rsp, 6);

    // Slave error on a read, consumer stalls with a new request held valid.
    fixed_waits = 1; rsp_mode = 2;
    r = '{w:1'b0, a:32'h0000_0E10, d:32'h0, s:4'h0, p:3'd0};
    issue(r, 1'b0);
    g = 0;
    while (!rsp_valid_o && g < 20) begin @(negedge clk_i); g++; end
    chk("stall_rsp_seen", rsp_valid_o, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("stall_rsp_valid", rsp_valid_o, 1'b1);
      chk("stall_rsp_data", {rsp_err_o, rsp_rdata_o}, {1'b1, ~r.a});
      chk("stall_req_ready", req_ready_o, 1'b0);
      chk("stall_no_setup", psel_o, 1'b0);
      if (i == 4) rsp_mode = 0;
      if (i < 5) @(negedge clk_i);
    end
    @(negedge clk_i);
    chk("stall_release_ready", req_ready_o, 1'b1);
    exp_push(r, 1'b0);
    trace(40);
    chk("repeat_rsp_cycle", t_rsp, 4);

    // Reset during ACCESS.
    fixed_waits = 10;
    issue('{w:1'b0, a:32'h104, d:32'h0, s:4'h0, p:3'd0}, 1'b0);
    @(negedge clk_i); req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_mid_in_access", {psel_o, penable_o}, 2'b11);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_mid_apb_drop", {psel_o, penable_o}, 2'b00);
    chk("rst_mid_rsp_valid", rsp_valid_o, 1'b0);
    void'(rsp_q.pop_back());
    @(negedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_idle_after", {req_ready_o, psel_o}, 2'b10);
    fixed_waits = 0;
    issue('{w:1'b0, a:32'h104, d:32'h0, s:4'h0, p:3'd3}, 1'b0);
    trace(40);
    chk("rst_mid_restart_rsp", t_rsp, 3);

`ifdef APB4_MST_TIMEOUT_EN
    // Abort after four silent ACCESS cycles; a write abort must leave memory untouched.
    fixed_waits = 100;
    issue('{w:1'b0, a:32'h108, d:32'h0, s:4'h0, p:3'd0}, 1'b1);
    trace(40);
    chk("tmo_rd_penable_cycles", t_pen, 4);
    chk("tmo_rd_rsp_cycle", t_rsp, 6);
    issue('{w:1'b1, a:32'h10C, d:32'hCAFE_F00D, s:4'hF, p:3'd0}, 1'b1);
    trace(40);
    chk("tmo_wr_penable_cycles", t_pen, 4);
    fixed_waits = 0;
    issue('{w:1'b0, a:32'h10C, d:32'h0, s:4'h0, p:3'd0}, 1'b0);
    trace(40);
    // pready on exactly the fourth ACCESS cycle completes normally.
    fixed_waits = 3;
    issue('{w:1'b0, a:32'h108, d:32'h0, s:4'h0, p:3'd0}, 1'b0);
    trace(40);
    chk("tmo_edge_penable_cycles", t_pen, 4);
    chk("tmo_edge_rsp_cycle", t_rsp, 6);
`endif

    // Randomized traffic with random wait states and consumer backpressure.
    fixed_waits = -1; rsp_mode = 1;
    for (int n = 0; n < 300; n++) begin
      a = 32'h0000_0100 | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a[11:8] = 4'hE;
      r.w = 1'($urandom); r.a = a; r.d = $urandom; r.s = 4'($urandom); r.p = 3'($urandom);
      issue(r, 1'b0);
      @(negedge clk_i);
      req_valid_i = 1'b0; scramble();
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    rsp_mode = 0;
    g = 0;
    while ((rsp_q.size() != 0 || !req_ready_o) && g < 200) begin @(negedge clk_i); g++; end
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("apb_queue_drained", apb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
